// File: rtl/train_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : train_step_sequencer
// Description : Route step sequencer for a 16-step train route. Drives the
//               step index (Selector) to the track-condition synchronizer and
//               advances when the returned condition Y has been high for
//               CONFIRM_CYCLES consecutive RUN cycles. Steps 2..5 are station
//               dwell steps. In these steps the motor is off and TIMER rises
//               after DWELL_CYCLES RUN cycles.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK        in   system clock, rising edge
//   RST_N      in   synchronous active-low reset
//   Enable     in   operator run request (level)
//   Stop       in   emergency stop
//   Y          in   advance condition for the current Selector
//   Selector   out  [3:0] current step index (registered)
//   TIMER      out  dwell elapsed (registered level)
//   Motor_En   out  motor drive enable
//   Dir        out  0 = forward (steps 0-7), 1 = reverse (steps 8-15)
//   Step_Done  out  one-cycle pulse per step advance
//   Running    out  high in RUN
//   Fault      out  watchdog fault flag
// Build option
//   WATCHDOG_EN : adds a per-step age counter and a latched FAULT state.
//                 When the macro is undefined, Fault is tied low.
// ============================================================================
module train_step_sequencer #(
    parameter int DWELL_CYCLES   = 50000000,
    parameter int CONFIRM_CYCLES = 4,
    parameter int WDOG_CYCLES    = 268435456
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       Enable,
    input  logic       Stop,
    input  logic       Y,
    output logic [3:0] Selector,
    output logic       TIMER,
    output logic       Motor_En,
    output logic       Dir,
    output logic       Step_Done,
    output logic       Running,
    output logic       Fault
);

    localparam int c_CONF_W  = $clog2(CONFIRM_CYCLES + 1);
    localparam int c_DWELL_W = $clog2(DWELL_CYCLES + 1);
    localparam logic [c_CONF_W-1:0]  c_CONF_LAST  = c_CONF_W'(CONFIRM_CYCLES - 1);
    localparam logic [c_DWELL_W-1:0] c_DWELL_LAST = c_DWELL_W'(DWELL_CYCLES - 1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_RUN   = 2'd1;
    localparam logic [1:0] c_S_HALT  = 2'd2;
`ifdef WATCHDOG_EN
    localparam logic [1:0] c_S_FAULT = 2'd3;
`endif

    logic [1:0]           r_state;
    logic [1:0]           w_nextState;
    logic [3:0]           r_selector;
    logic                 r_timer;
    logic                 r_stepDone;
    logic [c_CONF_W-1:0]  r_confirmCnt;
    logic [c_DWELL_W-1:0] r_dwellCnt;

    logic w_inRun;
    logic w_runNormal;
    logic w_dwellStep;
    logic w_advance;
    logic w_stopAct;

    assign w_inRun     = (r_state == c_S_RUN);
    // Normal RUN cycle: no stop and no enable drop on this edge.
    assign w_runNormal = w_inRun && !Stop && Enable;
    assign w_dwellStep = (r_selector >= 4'd2) && (r_selector <= 4'd5);
    assign w_advance   = w_runNormal && Y && (r_confirmCnt == c_CONF_LAST);

`ifdef WATCHDOG_EN
    localparam int c_WDOG_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [c_WDOG_W-1:0] c_WDOG_LAST = c_WDOG_W'(WDOG_CYCLES - 1);

    logic [c_WDOG_W-1:0] r_wdogCnt;
    logic                w_wdogExpire;

    // An advance on the expiry edge takes precedence and restarts the age.
    assign w_wdogExpire = w_runNormal && !w_advance && (r_wdogCnt == c_WDOG_LAST);
    // FAULT ignores Stop; only reset leaves it.
    assign w_stopAct    = Stop && (r_state != c_S_FAULT);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_wdogCnt <= '0;
        end else if (w_runNormal && !w_advance) begin
            r_wdogCnt <= r_wdogCnt + c_WDOG_W'(1);
        end else begin
            r_wdogCnt <= '0;
        end
    end
`else
    logic w_unusedWdog;
    assign w_unusedWdog = (WDOG_CYCLES > 0);
    assign w_stopAct    = Stop;
`endif

    // ---------------------------------------------------------------- state
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // ------------------------------------------------------------ next state
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (Stop) begin
                    w_nextState = c_S_HALT;
                end else if (Enable) begin
                    w_nextState = c_S_RUN;
                end
            end
            c_S_RUN: begin
                if (Stop) begin
                    w_nextState = c_S_HALT;
                end else if (!Enable) begin
                    w_nextState = c_S_IDLE;
                end
`ifdef WATCHDOG_EN
                else if (w_wdogExpire) begin
                    w_nextState = c_S_FAULT;
                end
`endif
            end
            c_S_HALT: begin
                if (!Stop) begin
                    w_nextState = c_S_IDLE;
                end
            end
`ifdef WATCHDOG_EN
            c_S_FAULT: begin
                w_nextState = c_S_FAULT;
            end
`endif
            default: begin
                w_nextState = c_S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        Running  = w_inRun;
        Motor_En = w_inRun && !w_dwellStep;
`ifdef WATCHDOG_EN
        Fault    = (r_state == c_S_FAULT);
`else
        Fault    = 1'b0;
`endif
    end

    assign Selector  = r_selector;
    assign Dir       = r_selector[3];
    assign TIMER     = r_timer;
    assign Step_Done = r_stepDone;

    // ------------------------------------------------- step / dwell datapath
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_selector   <= 4'd0;
            r_timer      <= 1'b0;
            r_stepDone   <= 1'b0;
            r_confirmCnt <= '0;
            r_dwellCnt   <= '0;
        end else begin
            r_stepDone <= w_advance;
            if (w_stopAct) begin
                // Going to HALT: a resumed dwell must restart from zero.
                r_confirmCnt <= '0;
                r_dwellCnt   <= '0;
                r_timer      <= 1'b0;
            end else if (w_runNormal) begin
                if (w_advance) begin
                    r_selector   <= r_selector + 4'd1;
                    r_confirmCnt <= '0;
                    r_dwellCnt   <= '0;
                    r_timer      <= 1'b0;
                end else begin
                    r_confirmCnt <= Y ? (r_confirmCnt + c_CONF_W'(1)) : '0;
                    if (w_dwellStep && !r_timer) begin
                        if (r_dwellCnt == c_DWELL_LAST) begin
                            r_timer <= 1'b1;
                        end else begin
                            r_dwellCnt <= r_dwellCnt + c_DWELL_W'(1);
                        end
                    end
                end
            end else begin
                // IDLE, HALT, FAULT, or leaving RUN on Enable low: Y is ignored.
                // Selector and the dwell progress are kept.
                r_confirmCnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire
